fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 36 +++
 rtl/fetch_queue_if.sv | 43 ++++
 rtl/fetch_queue_ram.sv | 30 +++
 rtl/fetch_queue.sv | 98 +++++++++
 tb/tb_fetch_queue.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_queue_pkg                                                   |
// | Field widths and packed-entry layout shared by the fetch queue.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package fetch_queue_pkg;

    localparam int c_pc_w     = 32;
    localparam int c_inst_w   = 32;
    localparam int c_pdir_w   = 1;
    localparam int c_meta_w   = 14;
    localparam int c_entry_w  = c_pc_w + c_inst_w + c_pdir_w + c_meta_w;

    localparam int c_pc_lsb   = 0;
    localparam int c_inst_lsb = c_pc_lsb + c_pc_w;
    localparam int c_pdir_lsb = c_inst_lsb + c_inst_w;
    localparam int c_meta_lsb = c_pdir_lsb + c_pdir_w;

    function automatic logic [c_entry_w-1:0] pack_entry(
        input logic [c_pc_w-1:0]   pc,
        input logic [c_inst_w-1:0] inst,
        input logic                p_dir,
        input logic [c_meta_w-1:0] meta
    );
        logic [c_entry_w-1:0] v;
        v = '0;
        v[c_pc_lsb   +: c_pc_w]   = pc;
        v[c_inst_lsb +: c_inst_w] = inst;
        v[c_pdir_lsb]             = p_dir;
        v[c_meta_lsb +: c_meta_w] = meta;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_queue_if                                                    |
// | Predictor-side push, decode-side pop and status signals.          |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 8
);
    localparam int c_cnt_w = $clog2(DEPTH) + 1;

    logic                in_valid;
    logic [c_pc_w-1:0]   in_pc;
    logic [c_inst_w-1:0] in_inst;
    logic                in_p_dir;
    logic [c_meta_w-1:0] in_meta;
    logic                flush;
    logic                bpred_stall;
    logic                out_valid;
    logic                out_ready;
    logic [c_pc_w-1:0]   out_pc;
    logic [c_inst_w-1:0] out_inst;
    logic                out_p_dir;
    logic [c_meta_w-1:0] out_meta;
    logic [c_cnt_w-1:0]  count;
    logic                overflow_err;

    modport master (
        output in_valid, in_pc, in_inst, in_p_dir, in_meta, flush, out_ready,
        input  bpred_stall, out_valid, out_pc, out_inst, out_p_dir, out_meta,
               count, overflow_err
    );

    modport slave (
        input  in_valid, in_pc, in_inst, in_p_dir, in_meta, flush, out_ready,
        output bpred_stall, out_valid, out_pc, out_inst, out_p_dir, out_meta,
               count, overflow_err
    );

endinterface
`default_nettype wire

// File: rtl/fetch_queue_ram.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fq_ram                                                            |
// | DEPTH x WIDTH storage, one write port, asynchronous read port.    |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module fq_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 79
) (
    input  wire logic                     clk,
    input  wire logic                     we,
    input  wire logic [$clog2(DEPTH)-1:0] waddr,
    input  wire logic [WIDTH-1:0]         wdata,
    input  wire logic [$clog2(DEPTH)-1:0] raddr,
    output logic      [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fetch_queue                                                       |
// | Instruction queue between branch predictor and decode.            |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int AF_MARGIN = 2
) (
    input  wire logic    clk,
    input  wire logic    reset,
    fetch_queue_if.slave bus
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt  = c_cnt_w'(DEPTH);
    localparam logic [c_cnt_w-1:0] c_stall_cnt = c_cnt_w'(DEPTH - AF_MARGIN);

    logic [c_ptr_w-1:0]   r_head;
    logic [c_ptr_w-1:0]   r_tail;
    logic [c_cnt_w-1:0]   r_count;
    logic                 r_stall;
    logic                 r_ovf;

    logic                 w_full;
    logic                 w_not_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [c_entry_w-1:0] w_wdata;
    logic [c_entry_w-1:0] w_rdata;

    // Full is taken from the registered count so a same-cycle pop never frees a slot.
    assign w_full      = (r_count == c_full_cnt);
    assign w_not_empty = (r_count != '0);
    assign w_push      = bus.in_valid & ~w_full & ~bus.flush;
    assign w_pop       = w_not_empty & bus.out_ready & ~bus.flush;
    assign w_wdata     = pack_entry(bus.in_pc, bus.in_inst, bus.in_p_dir, bus.in_meta);

    fq_ram #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_ram (
        .clk   (clk),
        .we    (w_push),
        .waddr (r_tail),
        .wdata (w_wdata),
        .raddr (r_head),
        .rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_stall <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            // Lags count by one cycle to cover the predictor's in-flight fetch.
            r_stall <= (r_count >= c_stall_cnt);
            if (bus.flush) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (bus.in_valid && w_full) begin
                    r_ovf <= 1'b1;
                end
                if (w_push) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_pop) begin
                    r_head <= r_head + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign bus.out_valid    = w_not_empty;
    assign bus.out_pc       = w_not_empty ? w_rdata[c_pc_lsb +: c_pc_w]     : '0;
    assign bus.out_inst     = w_not_empty ? w_rdata[c_inst_lsb +: c_inst_w] : '0;
    assign bus.out_p_dir    = w_not_empty & w_rdata[c_pdir_lsb];
    assign bus.out_meta     = w_not_empty ? w_rdata[c_meta_lsb +: c_meta_w] : '0;
    assign bus.count        = r_count;
    assign bus.bpred_stall  = r_stall;
    assign bus.overflow_err = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fetch_queue                                                    |
// | Directed bench with a queue-based reference model.                |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_fetch_queue;

    localparam int DEPTH     = 8;
    localparam int AF_MARGIN = 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        p_dir;
        logic [13:0] meta;
    } ent_t;

    logic clk;
    logic reset;

    fetch_queue_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue #(
        .DEPTH     (DEPTH),
        .AF_MARGIN (AF_MARGIN)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t mq[$];
    int   m_stall;
    int   m_ovf;
    bit   chk_en;
    int   n_tests;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a plain FIFO of entries; stall reflects last cycle's occupancy.
    task automatic model_update();
        int   n;
        ent_t e;
        n = mq.size();
        if (reset) begin
            mq.delete();
            m_stall = 0;
            m_ovf   = 0;
            chk_en  = 1'b1;
        end else begin
            m_stall = (n >= DEPTH - AF_MARGIN) ? 1 : 0;
            if (bus.flush) begin
                mq.delete();
            end else begin
                if (bus.in_valid && n == DEPTH) m_ovf = 1;
                if (n > 0 && bus.out_ready) void'(mq.pop_front());
                if (bus.in_valid && n != DEPTH) begin
                    e.pc = bus.in_pc; e.inst = bus.in_inst;
                    e.p_dir = bus.in_p_dir; e.meta = bus.in_meta;
                    mq.push_back(e);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                          input logic pd, input logic [13:0] meta);
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_inst  = inst;
        bus.in_p_dir = pd;
        bus.in_meta  = meta;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (mq.size() != 0) begin
                check("out_valid", 32'(bus.out_valid), 32'd1);
                check("out_pc",    bus.out_pc,         mq[0].pc);
                check("out_inst",  bus.out_inst,       mq[0].inst);
                check("out_p_dir", 32'(bus.out_p_dir), 32'(mq[0].p_dir));
                check("out_meta",  32'(bus.out_meta),  32'(mq[0].meta));
            end else begin
                check("out_valid", 32'(bus.out_valid), 32'd0);
                check("out_pc",    bus.out_pc,         32'd0);
                check("out_inst",  bus.out_inst,       32'd0);
                check("out_p_dir", 32'(bus.out_p_dir), 32'd0);
                check("out_meta",  32'(bus.out_meta),  32'd0);
            end
            check("count",        32'(bus.count),        32'(mq.size()));
            check("bpred_stall",  32'(bus.bpred_stall),  32'(m_stall));
            check("overflow_err", 32'(bus.overflow_err), 32'(m_ovf));
        end
    end

    initial begin
        chk_en = 1'b0;
        n_tests = 0;
        n_fail = 0;
        m_stall = 0;
        m_ovf = 0;
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        set_in(1'b1, 32'hFFFF_0000, 32'h1, 1'b1, 14'h3FFF);
        step();
        step();
        reset = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 14'h0);
        step();
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_stall", 32'(bus.bpred_stall), 32'd0);
        check("rst_ovf",   32'(bus.overflow_err), 32'd0);

        // In-order delivery, one-cycle latency
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'(i * 4), 32'h0000_0013 + 32'(i), i[0], 14'(12'h010 + i));
            step();
            if (i == 0) check("first_valid", 32'(bus.out_valid), 32'd1);
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 14'h0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("order_pc", bus.out_pc, 32'(i * 4));
            step();
        end
        check("drain_valid", 32'(bus.out_valid), 32'd0);

        // Fill to full and overflow
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            set_in(1'b1, 32'h1000 + 32'(4 * k), 32'hC000_0000 | 32'(k), k[0], 14'(k));
            step();
            if (k <= 8) check("fill_count", 32'(bus.count), 32'(k));
            if (k == 6) check("stall_lo6", 32'(bus.bpred_stall), 32'd0);
            if (k == 7) check("stall_hi7", 32'(bus.bpred_stall), 32'd1);
            if (k == 8) check("ovf_pre",   32'(bus.overflow_err), 32'd0);
            if (k == 9) begin
                check("ovf_count", 32'(bus.count), 32'd8);
                check("ovf_set",   32'(bus.overflow_err), 32'd1);
            end
        end

        // Push while full with simultaneous pop: push dropped
        set_in(1'b1, 32'hDEAD_0000, 32'hDEAD_BEEF, 1'b0, 14'h0);
        bus.out_ready = 1'b1;
        step();
        check("fullpop_count", 32'(bus.count), 32'd7);
        check("fullpop_ovf",   32'(bus.overflow_err), 32'd1);
        check("fullpop_head",  bus.out_pc, 32'h1008);

        // Flush at count 5
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 14'h0);
        step();
        step();
        check("pre_flush_count", 32'(bus.count), 32'd5);
        set_in(1'b1, 32'hBAD0_0000, 32'h0, 1'b1, 14'h1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 14'h0);
        bus.out_ready = 1'b0;
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_valid", 32'(bus.out_valid), 32'd0);
        check("flush_pc",    bus.out_pc, 32'd0);
        check("flush_ovf",   32'(bus.overflow_err), 32'd1);
        set_in(1'b1, 32'h200, 32'h2000, 1'b1, 14'h0AA);
        step();
        check("post_flush_pc", bus.out_pc, 32'h200);

        // Steady push+pop at count 3 with pointer wrap
        set_in(1'b1, 32'h204, 32'h2004, 1'b0, 14'h0AB);
        step();
        set_in(1'b1, 32'h208, 32'h2008, 1'b1, 14'h0AC);
        step();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            set_in(1'b1, 32'h300 + 32'(4 * i), 32'hA000_0000 | 32'(i), i[1], 14'h2ABC);
            step();
            check("steady_count", 32'(bus.count), 32'd3);
        end
        check("steady_head_pc",   bus.out_pc, 32'h344);
        check("steady_head_meta", 32'(bus.out_meta), 32'h2ABC);
        check("steady_head_inst", bus.out_inst, 32'hA000_0011);

        // Reset mid-operation with overflow set
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 32'h400 + 32'(4 * i), 32'h0, 1'b0, 14'h5);
            step();
        end
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 14'h0);
        step();
        check("pre_rst_count", 32'(bus.count), 32'd6);
        check("pre_rst_stall", 32'(bus.bpred_stall), 32'd1);
        check("pre_rst_ovf",   32'(bus.overflow_err), 32'd1);
        reset = 1'b1;
        bus.flush = 1'b1;
        set_in(1'b1, 32'h500, 32'h0, 1'b0, 14'h0);
        step();
        reset = 1'b0;
        bus.flush = 1'b0;
        set_in(1'b0, 32'h0, 32'h0, 1'b0, 14'h0);
        check("mid_rst_count", 32'(bus.count), 32'd0);
        check("mid_rst_stall", 32'(bus.bpred_stall), 32'd0);
        check("mid_rst_ovf",   32'(bus.overflow_err), 32'd0);
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
